// File: rtl/seven_segment_scan_counter.sv
// Multi-digit BCD up/down counter with programmable tick prescaler, time-multiplexed
// onto a shared seven-segment bus with one-hot digit enables and leading-zero blanking.
module seven_segment_scan_counter #(
  parameter int DIGITS = 4,
  parameter int TICK_W = 24,
  parameter int SCAN_W = 10,
  parameter int BLANK  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clear,
  input  logic [TICK_W-1:0]     tick_limit,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit_en,
  output logic [4*DIGITS-1:0]   value,
  output logic                  wrap
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VAL_W = 4 * DIGITS;

  logic [TICK_W-1:0] presc_reg;
  logic [VAL_W-1:0]  value_reg;
  logic              wrap_reg;
  logic [SCAN_W-1:0] scan_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [6:0]        seg_reg;
  logic              dp_reg;
  logic [DIGITS-1:0] digit_en_reg;

  logic              tick;
  logic [VAL_W-1:0]  value_inc;
  logic [VAL_W-1:0]  value_dec;
  logic [DIGITS-1:0] digit_nine;
  logic [DIGITS-1:0] digit_zero;
  logic [DIGITS-1:0] digit_blank;
  logic              wrap_up;
  logic              wrap_dn;

  logic [VAL_W-1:0]  value_shift;
  logic [3:0]        sel_digit;
  logic [DIGITS-1:0] blank_shift;
  logic [6:0]        seg_next;
  logic              dp_next;
  logic [DIGITS-1:0] digit_en_next;

  // >= rather than == so a lowered limit takes effect on the next enabled edge
  assign tick = en && (presc_reg >= tick_limit);

  // Per-digit BCD step. Carry/borrow into a digit is the AND of the lower-digit
  // flags rather than a rippled vector, which keeps the netlist free of self-loops.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] d;
      logic       carry_in;
      logic       borrow_in;

      assign d              = value_reg[4*gi +: 4];
      assign digit_nine[gi] = (d == 4'd9);
      assign digit_zero[gi] = (d == 4'd0);

      if (gi == 0) begin : g_lsd
        assign carry_in       = 1'b1;
        assign borrow_in      = 1'b1;
        assign digit_blank[gi] = 1'b0;
      end else begin : g_upper
        assign carry_in        = &digit_nine[gi-1:0];
        assign borrow_in       = &digit_zero[gi-1:0];
        assign digit_blank[gi] = &digit_zero[DIGITS-1:gi];
      end

      assign value_inc[4*gi +: 4] = !carry_in  ? d :
                                    (d == 4'd9) ? 4'd0 : d + 4'd1;
      assign value_dec[4*gi +: 4] = !borrow_in ? d :
                                    (d == 4'd0) ? 4'd9 : d - 4'd1;
    end
  endgenerate

  assign wrap_up = &digit_nine;
  assign wrap_dn = &digit_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg <= '0;
      value_reg <= '0;
      wrap_reg  <= 1'b0;
    end else if (clear) begin
      presc_reg <= '0;
      value_reg <= '0;
      wrap_reg  <= 1'b0;
    end else if (tick) begin
      presc_reg <= '0;
      value_reg <= up ? value_inc : value_dec;
      wrap_reg  <= up ? wrap_up : wrap_dn;
    end else begin
      if (en) begin
        presc_reg <= presc_reg + TICK_W'(1);
      end
      wrap_reg <= 1'b0;
    end
  end

  // Scan divider free-runs regardless of en/clear so the display never stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_reg <= '0;
    end else begin
      scan_reg <= scan_reg + SCAN_W'(1);
    end
  end

  generate
    if (DIGITS == 1) begin : g_single
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          idx_reg <= '0;
        end else begin
          idx_reg <= '0;
        end
      end
    end else begin : g_multi
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          idx_reg <= '0;
        end else if (&scan_reg) begin
          if (idx_reg == IDX_W'(DIGITS - 1)) begin
            idx_reg <= '0;
          end else begin
            idx_reg <= idx_reg + IDX_W'(1);
          end
        end
      end
    end
  endgenerate

  function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
    logic [6:0] s;
    case (bcd)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Shifts instead of indexed selects so non-power-of-two DIGITS stay in range
  assign value_shift = value_reg >> {idx_reg, 2'b00};
  assign sel_digit   = value_shift[3:0];
  assign blank_shift = digit_blank >> idx_reg;

  always_comb begin
    seg_next = seg_decode(sel_digit);
    if ((BLANK != 0) && blank_shift[0]) begin
      seg_next = 7'h00;
    end
  end

  assign dp_next       = (idx_reg == '0) && !en;
  assign digit_en_next = DIGITS'(1) << idx_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_reg      <= '0;
      dp_reg       <= 1'b0;
      digit_en_reg <= '0;
    end else begin
      seg_reg      <= seg_next;
      dp_reg       <= dp_next;
      digit_en_reg <= digit_en_next;
    end
  end

  assign seg      = seg_reg;
  assign dp       = dp_reg;
  assign digit_en = digit_en_reg;
  assign value    = value_reg;
  assign wrap     = wrap_reg;

endmodule
